// File: rtl/rgb_stream_to_vga_if.sv
// Avalon-ST RGB pixel stream carried between the colour mapper and
// the VGA display stage.
interface rgb_stream_to_vga_if;
    logic [23:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic        valid;
    logic        ready;

    modport master (
        output data,
        output startofpacket,
        output endofpacket,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  startofpacket,
        input  endofpacket,
        input  valid,
        output ready
    );
endinterface

// File: rtl/rgb_stream_to_vga.sv
// VGA display stage: buffers RGB stream packets (one per frame) and
// replays them against free-running raster timing.
module rgb_stream_to_vga #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               CLK_clk,
    input  logic               RESET_reset_n,
    rgb_stream_to_vga_if.slave RGB_SINK,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               UNDERFLOW,
    output logic               FRAME_ERR
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_END      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_END      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic        eop;
        logic        sop;
        logic [23:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ALIGN  = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2
    } state_t;

    logic clk;
    logic rst_n;

    assign clk   = CLK_clk;
    assign rst_n = RESET_reset_n;

    logic [HW-1:0] h;
    logic [VW-1:0] v;

    logic active;
    logic origin;
    logic last_px;
    logic hs_zone;
    logic vs_zone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_END) begin
            h <= '0;
            v <= (v == V_END) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign active  = (h < H_ACT) && (v < V_ACT);
    assign origin  = (h == '0) && (v == '0);
    assign last_px = (h == H_ACT_LAST) && (v == V_ACT_LAST);
    assign hs_zone = (h >= HS_START) && (h < HS_END);
    assign vs_zone = (v >= VS_START) && (v < VS_END);

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    entry_t        head;
    entry_t        beat;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign head  = mem[rd_ptr];
    assign beat  = {RGB_SINK.endofpacket,
                    RGB_SINK.startofpacket,
                    RGB_SINK.data};

    state_t state;
    state_t state_next;

    logic sink_ready;
    logic take;
    logic starve;
    logic mismatch;
    logic fault;
    logic show;
    logic flush;
    logic push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ALIGN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ALIGN: begin
                if (RGB_SINK.valid && RGB_SINK.startofpacket) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (fault) begin
                    state_next = ALIGN;
                end else if (take) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (fault) begin
                    state_next = ALIGN;
                end
            end
            default: state_next = ALIGN;
        endcase
    end

    // take = this raster position wants a pixel from the FIFO head
    always_comb begin
        sink_ready = 1'b0;
        take       = 1'b0;
        flush      = 1'b0;
        unique case (1'b1)
            state == ALIGN: begin
                sink_ready = 1'b1;
                flush      = 1'b1;
            end
            state == ARMED: begin
                sink_ready = !full;
                take       = origin;
            end
            state == STREAM: begin
                sink_ready = !full;
                take       = active;
            end
            default: ;
        endcase
        starve   = take && empty;
        mismatch = take && !empty &&
                   ((head.sop != origin) || (head.eop != last_px));
        fault    = starve || mismatch;
        show     = take && !fault;
        flush    = flush || fault;
        push     = RGB_SINK.valid && sink_ready && !fault &&
                   ((state != ALIGN) || RGB_SINK.startofpacket);
    end

    assign RGB_SINK.ready = rst_n && sink_ready;

    // a flushing cycle may still capture a start-of-packet into slot 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (show) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(show);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[flush ? '0 : wr_ptr] <= beat;
        end
    end

    logic [23:0] pix;
    logic        hs_q;
    logic        vs_q;
    logic        blank_q;
    logic        uf_q;
    logic        fe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            uf_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            pix     <= show ? head.data : '0;
            hs_q    <= !hs_zone;
            vs_q    <= !vs_zone;
            blank_q <= active;
            uf_q    <= uf_q || starve;
            fe_q    <= fe_q || mismatch;
        end
    end

    assign VGA_R       = pix[23:16];
    assign VGA_G       = pix[15:8];
    assign VGA_B       = pix[7:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign UNDERFLOW   = uf_q;
    assign FRAME_ERR   = fe_q;

endmodule
